serial_addsub4: RTL and testbench

Multi-cycle, bit-serial two's-complement adder/subtractor. It reuses a single 1-bit full-adder cell across WIDTH clock cycles and reports sum, carryout and overflow with the same flag semantics as the team's combinational 4-bit adder. It serves as the area-minimal arithmetic path in the lab datapath and as a cross-check reference against the parallel adder in regression.

---
 rtl/serial_addsub4_pkg.sv | 22 ++
 rtl/serial_addsub4_full_adder.sv | 13 +
 rtl/serial_addsub4.sv | 109 ++++++++++
 tb/tb_serial_addsub4.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_addsub4_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding,
// counter sizing and the legal operand-width range.
package serial_addsub4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    function automatic bit width_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_addsub4_full_adder.sv
// Single-bit full adder cell, reused every cycle by the serial datapath.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub4.sv
// Bit-serial two's-complement add/subtract; one result bit per cycle, LSB first,
// with carryout/overflow flags registered when the MSB is processed.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SHIFT | one operand bit per cycle through the shared full adder
// DONE  | result valid, done pulses for one cycle
module serial_addsub4
    import serial_addsub4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);

    if (!width_legal(WIDTH)) begin : g_width_check
        $error("serial_addsub4: WIDTH must be in 2..32");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_s, fa_cout;
    logic             last_bit;
    logic             c_in_msb;

    full_adder_1bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    // carry into the MSB is simply the carry register while the MSB is in the adder
    assign c_in_msb = carry_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == SHIFT) || (state_q == DONE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // subtraction is a + ~b + 1: invert b here, +1 via carry-in
                        a_sr    <= a;
                        b_sr    <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        res_sr  <= '0;
                    end
                end
                SHIFT: begin
                    res_sr  <= {fa_s, res_sr[WIDTH-1:1]};
                    a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_bit) begin
                        sum      <= {fa_s, res_sr[WIDTH-1:1]};
                        carryout <= fa_cout;
                        overflow <= c_in_msb ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub4.sv
// Randomized self-checking bench for serial_addsub4 (WIDTH=4) against an
// integer-arithmetic reference model.
module tb_serial_addsub4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carryout, overflow;
    logic [W-1:0] sum;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] last_sum = '0;
    logic         last_cout = 1'b0;
    logic         last_ovf = 1'b0;

    serial_addsub4 #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carryout (carryout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {overflow, carryout, sum} from plain signed/unsigned arithmetic
    function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y, input logic s);
        int ux, uy, sx, sy, full, r;
        logic [3:0] rs;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 8) ? ux - 16 : ux;
        sy = (uy >= 8) ? uy - 16 : uy;
        if (s) begin
            full = ux + (15 - uy) + 1;
            r    = sx - sy;
        end else begin
            full = ux + uy;
            r    = sx + sy;
        end
        rs = 4'(full % 16);
        c  = (full >= 16);
        v  = (r < -8) || (r > 7);
        return {v, c, rs};
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_sum"}, 32'(sum), 32'(last_sum));
        chk({tag, "_cout"}, 32'(carryout), 32'(last_cout));
        chk({tag, "_ovf"}, 32'(overflow), 32'(last_ovf));
    endtask

    // Caller guarantees the DUT is in IDLE. noise toggles start while busy,
    // hold leaves start high so the next call is accepted back-to-back.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tbv, input logic ts,
                         input bit noise, input bit hold);
        logic [5:0] e;
        e = model(ta, tbv, ts);
        a = ta; b = tbv; sub = ts; start = 1'b1;
        tick();
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_done", 32'(done), 32'd0);
        if (!hold) start = 1'b0;
        a = 4'($urandom); b = 4'($urandom); sub = 1'($urandom);
        for (int i = 1; i <= W; i++) begin
            if (noise) start = 1'($urandom_range(0, 1));
            tick();
            if (i < W) begin
                chk("shift_done", 32'(done), 32'd0);
                chk("shift_busy", 32'(busy), 32'd1);
                check_outputs("shift_hold");
            end else begin
                last_sum  = e[3:0];
                last_cout = e[4];
                last_ovf  = e[5];
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_busy", 32'(busy), 32'd1);
                check_outputs("result");
            end
        end
        if (noise || hold) start = 1'b1;
        tick();
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        check_outputs("post_hold");
        if (!hold) start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            check_outputs("idle");
        end

        do_op(4'b0101, 4'b0011, 1'b0, 1'b0, 1'b0);
        chk("dir_0101p0011", {carryout, overflow, sum}, {1'b0, 1'b1, 4'b1000});

        do_op(4'b1101, 4'b0101, 1'b0, 1'b0, 1'b1);
        chk("dir_1101p0101", {carryout, overflow, sum}, {1'b1, 1'b0, 4'b0010});
        do_op(4'b1011, 4'b1100, 1'b0, 1'b0, 1'b0);
        chk("dir_1011p1100", {carryout, overflow, sum}, {1'b1, 1'b1, 4'b0111});

        do_op(4'b0011, 4'b0101, 1'b1, 1'b0, 1'b0);
        chk("dir_0011m0101", {carryout, overflow, sum}, {1'b0, 1'b0, 4'b1110});
        do_op(4'b1000, 4'b0001, 1'b1, 1'b0, 1'b0);
        chk("dir_1000m0001", {carryout, overflow, sum}, {1'b1, 1'b1, 4'b0111});
        do_op(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("dir_0000m0000", {carryout, overflow, sum}, {1'b1, 1'b0, 4'b0000});

        do_op(4'b0111, 4'b0001, 1'b0, 1'b1, 1'b0);

        // abort mid-operation with reset at edge k+2
        a = 4'b0110; b = 4'b0111; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        check_outputs("rst");
        do_op(4'b0110, 4'b1001, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            do_op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  (n % 5) == 3);
        end
        start = 1'b0;
        tick();
        tick();
        chk("final_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
